// File: rtl/bbox_crop_scaler_pkg.sv
// bbox_crop_scaler_pkg: frame geometry, bbox field slices, FSM states and gray conversion
package bbox_crop_scaler_pkg;
  localparam int FRAME_W = 160;
  localparam int FRAME_H = 90;
  localparam int XMIN_LSB = 24;
  localparam int XMAX_LSB = 16;
  localparam int YMIN_LSB = 8;
  localparam int YMAX_LSB = 0;
  typedef enum logic [2:0] {IDLE, LATCH, RD, CAP, OUT, DONE} state_t;
  function automatic logic [7:0] rgb_to_gray(input logic [23:0] rgb);
    logic [9:0] s;
    s = 10'(rgb[23:16]) + 10'({rgb[15:8], 1'b0}) + 10'(rgb[7:0]);
    return s[9:2];
  endfunction
endpackage

// File: rtl/bbox_crop_scaler_scale_index.sv
// bbox_scale_index: nearest-neighbour source address for thumbnail pixel (ox, oy)
module bbox_scale_index #(
  parameter int WIDTH = 160,
  parameter int OUT_SIZE = 32,
  parameter int ADDR_W = 15
) (
  input  logic [7:0]                    x_min,
  input  logic [7:0]                    y_min,
  input  logic [8:0]                    w,
  input  logic [8:0]                    h,
  input  logic [$clog2(OUT_SIZE)-1:0]   ox,
  input  logic [$clog2(OUT_SIZE)-1:0]   oy,
  output logic [ADDR_W-1:0]             mem_addr
);
  localparam int OW = $clog2(OUT_SIZE);
  logic [OW+8:0] px, py;
  logic [ADDR_W-1:0] sx, sy;
  always_comb begin
    px = {{OW{1'b0}}, w} * {9'd0, ox};
    py = {{OW{1'b0}}, h} * {9'd0, oy};
    sx = ADDR_W'(x_min) + ADDR_W'(px >> OW);
    sy = ADDR_W'(y_min) + ADDR_W'(py >> OW);
    mem_addr = sy * ADDR_W'(WIDTH) + sx;
  end
endmodule

// File: rtl/bbox_crop_scaler.sv
// bbox_crop_scaler: crops the tracked box from frame RAM into a scaled grayscale thumbnail stream
module bbox_crop_scaler
  import bbox_crop_scaler_pkg::*;
#(
  parameter int WIDTH = FRAME_W,
  parameter int HEIGHT = FRAME_H,
  parameter int OUT_SIZE = 32,
  parameter int ADDR_W = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       bbox_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [23:0]       mem_rdata,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              empty_err
);
  localparam int OW = $clog2(OUT_SIZE);
  state_t state_q, state_d;
  logic [7:0] x_min_q, x_min_d, x_max_q, x_max_d, y_min_q, y_min_d, y_max_q, y_max_d;
  logic [8:0] w_q, w_d, h_q, h_d;
  logic [OW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, empty_err_q, empty_err_d;
  logic [7:0] x_max_c, y_max_c;
  logic empty;
  bbox_scale_index #(.WIDTH(WIDTH), .OUT_SIZE(OUT_SIZE), .ADDR_W(ADDR_W)) u_idx (
    .x_min(x_min_q), .y_min(y_min_q), .w(w_q), .h(h_q), .ox(ox_q), .oy(oy_q), .mem_addr(mem_addr)
  );
  always_comb begin
    x_max_c = (x_max_q > 8'(WIDTH - 1)) ? 8'(WIDTH - 1) : x_max_q;
    y_max_c = (y_max_q > 8'(HEIGHT - 1)) ? 8'(HEIGHT - 1) : y_max_q;
    empty = (x_min_q > x_max_c) || (y_min_q > y_max_c);
    state_d = state_q;
    x_min_d = x_min_q;
    x_max_d = x_max_q;
    y_min_d = y_min_q;
    y_max_d = y_max_q;
    w_d = w_q;
    h_d = h_q;
    ox_d = ox_q;
    oy_d = oy_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    empty_err_d = empty_err_q;
    case (state_q)
      IDLE: if (start) begin
        x_min_d = bbox_in[XMIN_LSB +: 8];
        x_max_d = bbox_in[XMAX_LSB +: 8];
        y_min_d = bbox_in[YMIN_LSB +: 8];
        y_max_d = bbox_in[YMAX_LSB +: 8];
        empty_err_d = 1'b0;
        state_d = LATCH;
      end
      LATCH: begin
        w_d = {1'b0, x_max_c} - {1'b0, x_min_q} + 9'd1;
        h_d = {1'b0, y_max_c} - {1'b0, y_min_q} + 9'd1;
        ox_d = '0;
        oy_d = '0;
        empty_err_d = empty;
        state_d = empty ? DONE : RD;
      end
      RD: state_d = CAP;
      CAP: begin
        out_data_d = rgb_to_gray(mem_rdata);
        out_valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        out_valid_d = 1'b0;
        ox_d = ox_q + 1'b1;
        oy_d = (&ox_q) ? oy_q + 1'b1 : oy_q;
        state_d = (&ox_q && &oy_q) ? DONE : RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      w_q <= '0;
      h_q <= '0;
      ox_q <= '0;
      oy_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      empty_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      w_q <= w_d;
      h_q <= h_d;
      ox_q <= ox_d;
      oy_q <= oy_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      empty_err_q <= empty_err_d;
    end
  end
  assign mem_rd_en = state_q == RD;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign empty_err = empty_err_q;
endmodule

// File: tb/tb_bbox_crop_scaler.sv
// tb_bbox_crop_scaler: directed checks of cropping, scaling, backpressure, reset and empty boxes
module tb_bbox_crop_scaler;
  logic CLOCK_50 = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] bbox_in = '0;
  logic [14:0] mem_addr;
  logic mem_rd_en;
  logic [23:0] mem_rdata = '0;
  logic [7:0] out_data;
  logic out_valid;
  logic out_ready = 1'b1;
  logic busy, done, empty_err;
  logic fixed_mode = 1'b0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [14:0] rd_q[$];
  logic [7:0] beat_q[$];
  bbox_crop_scaler dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .bbox_in(bbox_in),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .empty_err(empty_err)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  function automatic logic [23:0] pat(input int a);
    return {8'(a * 7), 8'(a >> 3), 8'(a + 91)};
  endfunction
  function automatic int gray_of(input logic [23:0] c);
    return (int'(c[23:16]) + 2 * int'(c[15:8]) + int'(c[7:0])) / 4;
  endfunction
  function automatic int exp_addr(input logic [31:0] b, input int i);
    int xmin, xmax, ymin, ymax;
    xmin = int'(b[31:24]);
    xmax = int'(b[23:16]) > 159 ? 159 : int'(b[23:16]);
    ymin = int'(b[15:8]);
    ymax = int'(b[7:0]) > 89 ? 89 : int'(b[7:0]);
    return (ymin + ((i / 32) * (ymax - ymin + 1)) / 32) * 160 + xmin + ((i % 32) * (xmax - xmin + 1)) / 32;
  endfunction
  always @(posedge CLOCK_50) if (mem_rd_en) mem_rdata <= fixed_mode ? 24'h4080C0 : pat(int'(mem_addr));
  always @(negedge CLOCK_50) begin
    if (mem_rd_en) rd_q.push_back(mem_addr);
    if (out_valid && out_ready) beat_q.push_back(out_data);
    if (done) done_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_start(input logic [31:0] b);
    @(posedge CLOCK_50) #1;
    start = 1'b1;
    bbox_in = b;
    @(posedge CLOCK_50) #1;
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLOCK_50);
      cyc++;
    end while (!done && cyc < budget);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic verify_job(input string tag, input logic [31:0] b);
    int aerr, derr, ea;
    aerr = 0;
    derr = 0;
    check({tag, "_reads"}, rd_q.size(), 1024);
    check({tag, "_beats"}, beat_q.size(), 1024);
    for (int i = 0; i < 1024; i++) begin
      ea = exp_addr(b, i);
      if (i < rd_q.size() && int'(rd_q[i]) != ea) aerr++;
      if (i < beat_q.size() && int'(beat_q[i]) != (fixed_mode ? 8'h80 : gray_of(pat(ea)))) derr++;
    end
    check({tag, "_addr_errs"}, aerr, 0);
    check({tag, "_data_errs"}, derr, 0);
  endtask
  initial begin
    int cyc, d0, n;
    logic [7:0] held;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_done", done, 0);
    check("rst_err", empty_err, 0);
    reset_n = 1'b1;
    // full frame, free-running consumer
    rd_q.delete();
    beat_q.delete();
    d0 = done_cnt;
    do_start(32'h009F0059);
    wait_done(4000, cyc);
    check("t1_cycles", cyc, 3074);
    check("t1_rd0", rd_q.size() > 0 ? rd_q[0] : 15'h7FFF, 0);
    check("t1_rd1", rd_q.size() > 1 ? rd_q[1] : 15'h7FFF, 5);
    check("t1_rd2", rd_q.size() > 2 ? rd_q[2] : 15'h7FFF, 10);
    check("t1_row1", rd_q.size() > 32 ? rd_q[32] : 15'h7FFF, 320);
    @(negedge CLOCK_50);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_idle", busy, 0);
    verify_job("t1", 32'h009F0059);
    // empty box from tracker reset value
    rd_q.delete();
    beat_q.delete();
    do_start(32'h9F005900);
    wait_done(20, cyc);
    check("t2_cycles", cyc, 2);
    check("t2_err", empty_err, 1);
    repeat (5) @(negedge CLOCK_50);
    check("t2_err_hold", empty_err, 1);
    check("t2_reads", rd_q.size(), 0);
    check("t2_beats", beat_q.size(), 0);
    // degenerate single-pixel box, constant colour
    fixed_mode = 1'b1;
    rd_q.delete();
    beat_q.delete();
    do_start(32'h0A0A1414);
    check("t3_err_clr", empty_err, 0);
    wait_done(4000, cyc);
    check("t3_addr0", rd_q.size() > 0 ? rd_q[0] : 15'h7FFF, 3210);
    verify_job("t3", 32'h0A0A1414);
    fixed_mode = 1'b0;
    // backpressure on the first beat
    rd_q.delete();
    beat_q.delete();
    out_ready = 1'b0;
    do_start(32'h009F0059);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!out_valid && n < 10);
    check("t4_valid_seen", out_valid, 1);
    held = out_data;
    check("t4_first_data", held, gray_of(pat(0)));
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      check("t4_stall_valid", out_valid, 1);
      check("t4_stall_data", out_data, held);
      check("t4_stall_rd", mem_rd_en, 0);
    end
    @(posedge CLOCK_50) #1;
    out_ready = 1'b1;
    @(posedge CLOCK_50) #1;
    check("t4_valid_drop", out_valid, 0);
    check("t4_next_rd", mem_rd_en, 1);
    check("t4_beat_cnt", beat_q.size(), 1);
    wait_done(4000, cyc);
    verify_job("t4", 32'h009F0059);
    // mid-job reset after 100 beats
    rd_q.delete();
    beat_q.delete();
    do_start(32'h009F0059);
    n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (beat_q.size() < 100 && n < 1000);
    check("t5_reach100", beat_q.size() >= 100, 1);
    @(posedge CLOCK_50) #1;
    reset_n = 1'b0;
    @(posedge CLOCK_50) #1;
    reset_n = 1'b1;
    d0 = done_cnt;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_rd_en", mem_rd_en, 0);
    check("t5_done", done, 0);
    n = rd_q.size();
    repeat (10) @(negedge CLOCK_50);
    check("t5_no_reads", rd_q.size(), n);
    check("t5_no_done", done_cnt - d0, 0);
    rd_q.delete();
    beat_q.delete();
    do_start(32'h009F0059);
    wait_done(4000, cyc);
    check("t5_restart_rd0", rd_q.size() > 0 ? rd_q[0] : 15'h7FFF, 0);
    verify_job("t5", 32'h009F0059);
    // start and bbox changes during a job are ignored
    repeat (2) @(negedge CLOCK_50);
    rd_q.delete();
    beat_q.delete();
    d0 = done_cnt;
    do_start(32'h10201030);
    repeat (10) @(posedge CLOCK_50);
    #1;
    start = 1'b1;
    bbox_in = 32'h00000000;
    @(posedge CLOCK_50) #1;
    start = 1'b0;
    wait_done(4000, cyc);
    repeat (10) @(negedge CLOCK_50);
    check("t6_done_once", done_cnt - d0, 1);
    check("t6_idle", busy, 0);
    verify_job("t6", 32'h10201030);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
